pit_timer: RTL and testbench

PIT_TIMER -- requirements
Module: pit_timer

---
 rtl/pit_timer_pkg.sv | 17 +
 rtl/upcnt_w.sv | 47 ++++
 rtl/pit_timer.sv | 94 +++++++++
 tb/tb_pit_timer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pit_timer_pkg.sv
// ---------------------------------------------------------------
// pit_timer_pkg : shared constants for the programmable interval timer
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package pit_timer_pkg;

  localparam int   W_DEFAULT = 16;

  // cnt_sel encodings for the readback mux
  localparam logic CNT_PRE   = 1'b0;
  localparam logic CNT_DIV   = 1'b1;

endpackage : pit_timer_pkg

`default_nettype wire

// File: rtl/upcnt_w.sv
// ---------------------------------------------------------------
// upcnt_w : W-bit loadable up-counter with a per-bit ripple carry
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module upcnt_w
  import pit_timer_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         resl,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         ci,
  output logic [W-1:0] q,
  output logic         co
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W:0]   carry;

  // Bit i toggles when every lower bit is 1 and the chain is enabled by ci.
  always_comb begin
    carry[0] = ci;
    for (int i = 0; i < W; i++) begin
      carry[i+1] = carry[i] & q_q[i];
    end
    q_d = ld ? d : (q_q ^ carry[W-1:0]);
  end

  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign co = carry[W];

endmodule : upcnt_w

`default_nettype wire

// File: rtl/pit_timer.sv
// ---------------------------------------------------------------
// pit_timer : prescaler + divider interval timer with sticky pending flag
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pit_timer
  import pit_timer_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         resl,
  input  logic [W-1:0] din,
  input  logic         wr_pre,
  input  logic         wr_div,
  input  logic         int_ack,
  input  logic         cnt_sel,
  output logic [W-1:0] cnt_q,
  output logic         pit_int,
  output logic         int_pend
);

  logic [W-1:0] pre_q, pre_d;
  logic [W-1:0] div_q, div_d;
  logic         pit_int_q, pit_int_d;
  logic         int_pend_q, int_pend_d;

  logic [W-1:0] pre_cnt;
  logic [W-1:0] div_cnt;
  logic         wr;
  logic         en;
  logic         tick;
  logic         terminal;
  logic         unused_pre_co;
  logic         unused_div_co;

  always_comb begin
    pre_d = pre_q;
    div_d = div_q;
    if (wr_pre) pre_d = din;
    if (wr_div) div_d = din;

    wr       = wr_pre | wr_div;
    en       = (pre_q != '0);
    tick     = en && (pre_cnt == pre_q);
    terminal = tick && (div_cnt == div_q);

    // A register write restarts the period, so it also swallows a coincident pulse.
    pit_int_d  = terminal && !wr;
    int_pend_d = pit_int_d | (int_pend_q & ~int_ack);
  end

  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      pre_q      <= '0;
      div_q      <= '0;
      pit_int_q  <= 1'b0;
      int_pend_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      div_q      <= div_d;
      pit_int_q  <= pit_int_d;
      int_pend_q <= int_pend_d;
    end
  end

  upcnt_w #(.W(W)) u_pre_cnt (
    .clk  (clk),
    .resl (resl),
    .ld   (wr | tick),
    .d    ('0),
    .ci   (en),
    .q    (pre_cnt),
    .co   (unused_pre_co)
  );

  upcnt_w #(.W(W)) u_div_cnt (
    .clk  (clk),
    .resl (resl),
    .ld   (wr | terminal),
    .d    ('0),
    .ci   (tick),
    .q    (div_cnt),
    .co   (unused_div_co)
  );

  assign cnt_q    = (cnt_sel == CNT_DIV) ? div_cnt : pre_cnt;
  assign pit_int  = pit_int_q;
  assign int_pend = int_pend_q;

endmodule : pit_timer

`default_nettype wire

// File: tb/tb_pit_timer.sv
// ---------------------------------------------------------------
// tb_pit_timer : directed vector table plus corner sequences for pit_timer
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_pit_timer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         resl;
  logic [W-1:0] din;
  logic         wr_pre, wr_div, int_ack, cnt_sel;
  logic [W-1:0] cnt_q;
  logic         pit_int, int_pend;

  int n_chk = 0;
  int n_err = 0;

  pit_timer #(.W(W)) dut (
    .clk      (clk),
    .resl     (resl),
    .din      (din),
    .wr_pre   (wr_pre),
    .wr_div   (wr_div),
    .int_ack  (int_ack),
    .cnt_sel  (cnt_sel),
    .cnt_q    (cnt_q),
    .pit_int  (pit_int),
    .int_pend (int_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wp;
    logic         wd;
    logic [W-1:0] din;
    logic         ack;
    logic         sel;
    logic [W-1:0] e_cnt;
    logic         e_irq;
    logic         e_pend;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_pre  = 1'b0;
    wr_div  = 1'b0;
    int_ack = 1'b0;
    din     = '0;
  endtask

  initial begin
    int bad;

    // Columns: wr_pre, wr_div, din, int_ack, cnt_sel | cnt_q, pit_int, int_pend
    // Rows 0-9: PRE=3, DIV=0 (period 4). Rows 10-24: DIV=2, PRE=1 (period 6).
    tbl[0]  = '{1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 16'd2, 1'b0, 1'b1, 16'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 16'd1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1};

    resl    = 1'b0;
    cnt_sel = 1'b0;
    idle_inputs();
    repeat (3) step();
    chk("reset cnt_q", 32'(cnt_q), 32'd0);
    chk("reset pit_int", 32'(pit_int), 32'd0);
    chk("reset int_pend", 32'(int_pend), 32'd0);
    resl = 1'b1;
    step();

    for (int i = 0; i < 25; i++) begin
      wr_pre  = tbl[i].wp;
      wr_div  = tbl[i].wd;
      din     = tbl[i].din;
      int_ack = tbl[i].ack;
      cnt_sel = tbl[i].sel;
      #2;
      chk($sformatf("row%0d cnt_q", i), 32'(cnt_q), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d pit_int", i), 32'(pit_int), 32'(tbl[i].e_irq));
      chk($sformatf("row%0d int_pend", i), 32'(int_pend), 32'(tbl[i].e_pend));
      step();
    end
    idle_inputs();

    // Write in the terminal cycle: DIV=0 and PRE=3, then hit pc==3 with a DIV write.
    wr_div = 1'b1; din = 16'd0; int_ack = 1'b1;
    step();
    idle_inputs();
    wr_pre = 1'b1; din = 16'd3;
    step();
    idle_inputs();
    cnt_sel = 1'b0;
    repeat (3) step();
    #2;
    chk("term cycle cnt_q", 32'(cnt_q), 32'd3);
    wr_div = 1'b1; din = 16'd0;
    step();
    idle_inputs();
    #1;
    chk("term write pit_int", 32'(pit_int), 32'd0);
    chk("term write int_pend", 32'(int_pend), 32'd0);
    cnt_sel = 1'b1; #1;
    chk("term write div cnt", 32'(cnt_q), 32'd0);
    cnt_sel = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("restart k%0d cnt", k), 32'(cnt_q), 32'(k));
      chk($sformatf("restart k%0d pit_int", k), 32'(pit_int), 32'd0);
      step();
      #2;
    end
    chk("restart pulse", 32'(pit_int), 32'd1);
    chk("restart pend", 32'(int_pend), 32'd1);

    // Disable by writing PRE=0 while pulses are running.
    wr_pre = 1'b1; din = 16'd0;
    step();
    idle_inputs();
    bad = 0;
    for (int k = 0; k < 120; k++) begin
      cnt_sel = k[0];
      #2;
      if (cnt_q !== '0 || pit_int !== 1'b0) bad++;
      step();
    end
    chk("pre0 quiet cycles", 32'(bad), 32'd0);

    // Dual write PRE=DIV=5, then reset mid-count.
    wr_pre = 1'b1; wr_div = 1'b1; din = 16'd5;
    step();
    idle_inputs();
    repeat (6) step();
    cnt_sel = 1'b1; #1;
    chk("dual write div cnt", 32'(cnt_q), 32'd1);
    cnt_sel = 1'b0; #1;
    chk("dual write pre cnt", 32'(cnt_q), 32'd0);
    repeat (3) step();
    #2;
    chk("midcount pre cnt", 32'(cnt_q), 32'd3);
    chk("midcount pend", 32'(int_pend), 32'd1);
    resl = 1'b0;
    #1;
    chk("async rst cnt pre", 32'(cnt_q), 32'd0);
    chk("async rst pit_int", 32'(pit_int), 32'd0);
    chk("async rst int_pend", 32'(int_pend), 32'd0);
    cnt_sel = 1'b1; #1;
    chk("async rst cnt div", 32'(cnt_q), 32'd0);
    wr_pre = 1'b1; din = 16'd7;
    repeat (2) step();
    idle_inputs();
    resl = 1'b1;
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      cnt_sel = k[0];
      #2;
      if (cnt_q !== '0 || pit_int !== 1'b0 || int_pend !== 1'b0) bad++;
      step();
    end
    chk("post reset disabled", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_pit_timer

`default_nettype wire
